bubble_outbuffer_mc: RTL

Parametrised successor to the bubble output buffer. It provides an N-channel bit-serial page store feeding the bubble data-out pins. The loader streams bits in serially, and internal lane/word counters de-interleave them across channels. User pages are double-buffered (ping-pong), so a new page loads while the current one is read out. Sits between the SPI loader and the bubble timing generator.

---
 rtl/bubble_outbuffer_mc_pkg.sv | 26 ++
 rtl/bubble_lane_ram.sv | 46 ++++
 rtl/bubble_outbuffer_mc.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bubble_outbuffer_mc_pkg.sv
// Shared definitions for the multi-channel bubble output buffer.
// Access-type codes, load FSM state encoding, and the user-bank base
// address helper used by both the read and the write address paths.
package bubble_outbuffer_mc_pkg;

    localparam logic [2:0] ACC_BOOT = 3'b110;
    localparam logic [2:0] ACC_USER = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_SWAP   = 2'd3
    } state_t;

    // User bank base: all address bits above the bank bit are ones, the bank
    // bit selects ping or pong, the low USER_W bits are the word offset (zero).
    function automatic logic [31:0] user_base(input int unsigned addr_w,
                                              input int unsigned user_w,
                                              input logic        bank);
        logic [31:0] hi_ones;
        hi_ones = ((32'd1 << addr_w) - 32'd1) & ~((32'd1 << (user_w + 32'd1)) - 32'd1);
        return hi_ones | (32'(bank) << user_w);
    endfunction

endpackage

// File: rtl/bubble_lane_ram.sv
// Single-bit-wide page store for one DOUT lane.
// Ports:
//   clk, rst            clock, async active-high reset (read register only)
//   wr_en/wr_addr/wr_data   write port
//   rd_en               read clock enable (holds the register when low)
//   rd_zero             when enabled, load 0 instead of the RAM bit
//   rd_clr              force the read register to 0 (inactive lane)
//   rd_addr, rd_data    registered read port
module bubble_lane_ram #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    input  logic              rd_en,
    input  logic              rd_zero,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic mem [DEPTH];

    // Storage is never reset; partial loads survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read of mem gives old data on a same-address write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= 1'b0;
        end else if (rd_clr) begin
            rd_data <= 1'b0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? 1'b0 : mem[rd_addr];
        end
    end

endmodule

// File: rtl/bubble_outbuffer_mc.sv
// N-channel bit-serial page store feeding the bubble DOUT pins.
// A serial loader writes bits round-robin across the active lanes; user pages
// are ping-ponged so the next page loads while the current bank is read.
// CHANNELS must be 2 or 4; ADDR_W must exceed USER_W.
// Ports:
//   MCLK, RST           clock, async active-high reset
//   BITWIDTH4           1 = four active lanes, 0 = two
//   ACCTYPE             BOOT / USER / idle read selection
//   BOUTCYCLENUM        bubble output cycle number (read address source)
//   nBOUTCLKEN          active-low read strobe
//   LOAD_REQ/LOAD_BOOT/LOAD_WORDS   load request and its parameters
//   nOUTBUFWRCLKEN, OUTBUFWRDATA    serial write strobe and data
//   LOAD_BUSY, LOAD_DONE, ACTIVE_BANK   load status
//   DOUT                inverted lane data
module bubble_outbuffer_mc
    import bubble_outbuffer_mc_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned USER_W   = 10
) (
    input  logic                MCLK,
    input  logic                RST,
    input  logic                BITWIDTH4,
    input  logic [2:0]          ACCTYPE,
    input  logic [ADDR_W-1:0]   BOUTCYCLENUM,
    input  logic                nBOUTCLKEN,
    input  logic                LOAD_REQ,
    input  logic                LOAD_BOOT,
    input  logic [ADDR_W-1:0]   LOAD_WORDS,
    input  logic                nOUTBUFWRCLKEN,
    input  logic                OUTBUFWRDATA,
    output logic                LOAD_BUSY,
    output logic                LOAD_DONE,
    output logic                ACTIVE_BANK,
    output logic [CHANNELS-1:0] DOUT
);

    localparam int unsigned       USER_WORDS   = 2 ** USER_W;
    localparam logic [ADDR_W-1:0] USER_WORDS_A = ADDR_W'(USER_WORDS);
    localparam logic [ADDR_W-1:0] ONE_A        = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] wc;
    logic [ADDR_W-1:0] widx;
    logic [ADDR_W-1:0] base;
    logic [1:0]        lc;
    logic              boot_q;
    logic              wide_q;

    logic [ADDR_W-1:0] load_words_c;
    logic [1:0]        last_lane_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic              wr_strobe_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic              rd_zero_c;
    logic [CHANNELS-1:0] lane_q;

    // User loads are limited to one bank.
    assign load_words_c = (!LOAD_BOOT && (LOAD_WORDS > USER_WORDS_A)) ? USER_WORDS_A : LOAD_WORDS;
    assign last_lane_c  = wide_q ? 2'd3 : 2'd1;
    assign wr_addr_c    = base + widx;
    assign wr_strobe_c  = (state == ST_LOAD) && !nOUTBUFWRCLKEN;

    // Load sequencer: counts lanes within a word, then words, then hands off.
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            wc          <= '0;
            widx        <= '0;
            base        <= '0;
            lc          <= 2'd0;
            boot_q      <= 1'b0;
            wide_q      <= 1'b0;
            LOAD_BUSY   <= 1'b0;
            LOAD_DONE   <= 1'b0;
            ACTIVE_BANK <= 1'b0;
        end else begin
            LOAD_DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (LOAD_REQ) begin
                        boot_q    <= LOAD_BOOT;
                        wide_q    <= (CHANNELS == 4) && BITWIDTH4;
                        lc        <= 2'd0;
                        widx      <= '0;
                        wc        <= load_words_c;
                        base      <= LOAD_BOOT ? '0
                                               : ADDR_W'(user_base(ADDR_W, USER_W, ~ACTIVE_BANK));
                        LOAD_BUSY <= 1'b1;
                        state     <= (load_words_c == '0) ? ST_COMMIT : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!nOUTBUFWRCLKEN) begin
                        if (lc == last_lane_c) begin
                            lc   <= 2'd0;
                            widx <= widx + ONE_A;
                            wc   <= wc - ONE_A;
                            if (wc == ONE_A) begin
                                state <= ST_COMMIT;
                            end
                        end else begin
                            lc <= lc + 2'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (boot_q) begin
                        LOAD_DONE <= 1'b1;
                        LOAD_BUSY <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        state <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    // Hold the flip until the reader leaves USER mode.
                    if (ACCTYPE != ACC_USER) begin
                        ACTIVE_BANK <= ~ACTIVE_BANK;
                        LOAD_DONE   <= 1'b1;
                        LOAD_BUSY   <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Read address select; idle access loads zeros into the lane registers.
    always_comb begin
        rd_addr_c = '0;
        rd_zero_c = 1'b1;
        case (ACCTYPE)
            ACC_BOOT: begin
                rd_addr_c = BOUTCYCLENUM;
                rd_zero_c = 1'b0;
            end
            ACC_USER: begin
                rd_addr_c = ADDR_W'(user_base(ADDR_W, USER_W, ACTIVE_BANK))
                          | ADDR_W'(BOUTCYCLENUM[USER_W-1:0]);
                rd_zero_c = 1'b0;
            end
            default: begin
                rd_addr_c = '0;
                rd_zero_c = 1'b1;
            end
        endcase
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        logic lane_clr;
        logic lane_wr;

        // Upper lanes are parked at zero whenever only two lanes are in use.
        assign lane_clr = (i >= 2) && !BITWIDTH4;
        assign lane_wr  = wr_strobe_c && (lc == 2'(i));

        bubble_lane_ram #(
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk     (MCLK),
            .rst     (RST),
            .wr_en   (lane_wr),
            .wr_addr (wr_addr_c),
            .wr_data (OUTBUFWRDATA),
            .rd_en   (!nBOUTCLKEN),
            .rd_zero (rd_zero_c),
            .rd_clr  (lane_clr),
            .rd_addr (rd_addr_c),
            .rd_data (lane_q[i])
        );
    end

    assign DOUT = ~lane_q;

endmodule
